// File: rtl/rx_frame_packer_fifo.sv
// -----------------------------------------------------------------------------
// rx_frame_packer_fifo
//
// Receive back-end of the baseband chain. Takes the CDR bit stream, packs it
// LSB-first into DATA_WIDTH-bit words and buffers the words in a FIFO that the
// CPU side reads.
//
// Build option (macro SYNC_SEARCH_EN):
//   defined     : a framing FSM hunts for the sync word, reads a DATA_WIDTH-bit
//                 length field L and then packs L payload words. The length
//                 word itself is also written to the FIFO.
//   not defined : no framing; the packer free-runs from reset and every
//                 DATA_WIDTH valid bits become one FIFO word. o_sync_lock,
//                 o_len_err and o_frame_done are tied to 0.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_bit/i_bit_valid CDR data bit and its 1-cycle qualifier
//   i_clear           synchronous flush (FIFO, framing, sticky flags)
//   i_rd_en           read request; o_rd_data/o_rd_valid one cycle later
//   o_count           words stored (0..DEPTH), flags derived from it
//   o_full/o_empty/o_almost_full/o_almost_empty  FIFO level flags
//   o_overflow        sticky: a word was dropped because the FIFO was full
//   o_underflow       sticky: read requested while empty
//   o_len_err         1-cycle pulse: length field above MAX_LEN, frame dropped
//   o_sync_lock       high while reading the length field or the payload
//   o_frame_done      1-cycle pulse in the cycle the last frame word is written
// -----------------------------------------------------------------------------
module rx_frame_packer_fifo #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          FIFO_SIZE_BIT = 7,
  parameter int          SYNC_LEN      = 32,
  parameter logic [31:0] SYNC_WORD     = 32'hA700_0000,
  parameter int          MAX_LEN       = 127,
  parameter int          ALMOST_MARGIN = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_bit,
  input  logic                    i_bit_valid,
  input  logic                    i_clear,
  input  logic                    i_rd_en,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic [FIFO_SIZE_BIT:0]  o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_len_err,
  output logic                    o_sync_lock,
  output logic                    o_frame_done
);

  localparam int DEPTH = 1 << FIFO_SIZE_BIT;
  localparam int CNT_W = FIFO_SIZE_BIT + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C     = CNT_W'(DEPTH - ALMOST_MARGIN);
  localparam logic [CNT_W-1:0] AEMPTY_C    = CNT_W'(ALMOST_MARGIN);
  localparam logic [BIT_W-1:0] LAST_BIT_C  = BIT_W'(DATA_WIDTH - 1);

  // Reset and flush act identically on every control register.
  logic flush;
  assign flush = i_rst | i_clear;

  // ---------------------------------------------------------------------------
  // Bit packer
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] word_sr;     // partial word, newest bit at the MSB
  logic [DATA_WIDTH-1:0] word_nxt;    // word_sr after shifting in i_bit
  logic [BIT_W-1:0]      bit_cnt;     // bits collected in the current word
  logic                  collecting;  // packer accepts bits this cycle
  logic                  word_done;   // this valid bit completes a word
  logic                  wr_req;      // completed word must go to the FIFO
  logic                  wr_pending;  // staged write, performed this cycle
  logic [DATA_WIDTH-1:0] wr_data;

  // Shifting right and inserting at the MSB leaves the first received bit in
  // word[0] once DATA_WIDTH bits have arrived.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can
    // leave it unassigned and infer a latch.
    word_nxt                 = word_sr >> 1;
    word_nxt[DATA_WIDTH-1]   = i_bit;
  end

  assign word_done = i_bit_valid & collecting & (bit_cnt == LAST_BIT_C);

  // NOTE: state registers use non-blocking assignment so every always_ff reads
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      word_sr <= '0;
      bit_cnt <= '0;
    end else if (i_bit_valid && collecting) begin
      word_sr <= word_nxt;
      bit_cnt <= (bit_cnt == LAST_BIT_C) ? '0 : bit_cnt + 1'b1;
    end
  end

  // The FIFO write happens one cycle after the completing bit, from a staged
  // copy of the word, which keeps the FIFO write path off the packer logic.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_pending <= 1'b0;
      wr_data    <= '0;
    end else begin
      wr_pending <= wr_req;
      if (wr_req) wr_data <= word_nxt;
    end
  end

`ifdef SYNC_SEARCH_EN
  // ---------------------------------------------------------------------------
  // Framing FSM: SEARCH -> LEN -> PAYLOAD -> SEARCH
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [DATA_WIDTH:0] MAX_LEN_C = (DATA_WIDTH + 1)'(MAX_LEN);

  logic [1:0]            state;
  logic [SYNC_LEN-1:0]   sync_sr;    // last SYNC_LEN bits, newest at the MSB
  logic [SYNC_LEN-1:0]   sync_nxt;
  logic [DATA_WIDTH-1:0] len_q;      // payload length of the current frame
  logic [DATA_WIDTH-1:0] word_cnt;   // payload words completed so far
  logic                  len_too_long;
  logic                  len_err_q;
  logic                  frame_done_q;

  always_comb begin
    sync_nxt               = sync_sr >> 1;
    sync_nxt[SYNC_LEN-1]   = i_bit;
  end

  assign collecting   = (state == ST_LEN) || (state == ST_PAYLOAD);
  assign len_too_long = {1'b0, word_nxt} > MAX_LEN_C;
  // An over-long length word is discarded; every other completed word is stored.
  assign wr_req       = word_done & ~((state == ST_LEN) & len_too_long);

  always_ff @(posedge i_clk) begin
    if (flush) begin
      state        <= ST_SEARCH;
      sync_sr      <= '0;
      len_q        <= '0;
      word_cnt     <= '0;
      len_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      len_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (i_bit_valid) begin
            sync_sr <= sync_nxt;
            if (sync_nxt == SYNC_PAT) state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (word_done) begin
            if (len_too_long) begin
              len_err_q <= 1'b1;
              state     <= ST_SEARCH;
              sync_sr   <= '0;
            end else if (word_nxt == '0) begin
              // Empty frame: the length word is the whole frame.
              frame_done_q <= 1'b1;
              state        <= ST_SEARCH;
              sync_sr      <= '0;
            end else begin
              len_q    <= word_nxt;
              word_cnt <= '0;
              state    <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (word_done) begin
            if (word_cnt + 1'b1 == len_q) begin
              frame_done_q <= 1'b1;
              state        <= ST_SEARCH;
              sync_sr      <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  // frame_done_q rises together with wr_pending for the last word, so the
  // pulse lines up with the FIFO write (or the drop, when full).
  assign o_len_err    = len_err_q;
  assign o_frame_done = frame_done_q;
  assign o_sync_lock  = collecting;
`else
  // Free-running packer: every DATA_WIDTH valid bits form one word.
  assign collecting   = 1'b1;
  assign wr_req       = word_done;
  assign o_len_err    = 1'b0;
  assign o_frame_done = 1'b0;
  assign o_sync_lock  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_SIZE_BIT-1:0] wr_ptr;
  logic [FIFO_SIZE_BIT-1:0] rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     rd_accept;
  logic                     wr_accept;

  // A read in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted when it coincides with a read.
  assign rd_accept = i_rd_en & ~o_empty;
  assign wr_accept = wr_pending & (~o_full | rd_accept);

  // NOTE: the storage array has no reset; flushing only moves the pointers,
  // and stale contents are unreachable until rewritten.
  always_ff @(posedge i_clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_rd_valid <= rd_accept;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_rd_data <= mem[rd_ptr];
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_pending && !wr_accept) o_overflow  <= 1'b1;
      if (i_rd_en && o_empty)       o_underflow <= 1'b1;
    end
  end

  assign o_count        = count;
  assign o_full         = (count == DEPTH_C);
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= AFULL_C);
  assign o_almost_empty = (count <= AEMPTY_C);

endmodule

// File: tb/tb_rx_frame_packer_fifo.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_packer_fifo
//
// Directed bench for rx_frame_packer_fifo with default parameters
// (DATA_WIDTH=8, DEPTH=128, ALMOST_MARGIN=4). The free-running packer build is
// exercised by default; framing tests are compiled when SYNC_SEARCH_EN is set.
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_rx_frame_packer_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_bit;
  logic       i_bit_valid;
  logic       i_clear;
  logic       i_rd_en;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic [7:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_almost_full;
  logic       o_almost_empty;
  logic       o_overflow;
  logic       o_underflow;
  logic       o_len_err;
  logic       o_sync_lock;
  logic       o_frame_done;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  int len_err_seen = 0;
  int lock_seen = 0;

  rx_frame_packer_fifo dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_bit          (i_bit),
    .i_bit_valid    (i_bit_valid),
    .i_clear        (i_clear),
    .i_rd_en        (i_rd_en),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow),
    .o_len_err      (o_len_err),
    .o_sync_lock    (o_sync_lock),
    .o_frame_done   (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // Pulse/level observers; each 1-cycle pulse is seen exactly once.
  always @(posedge i_clk) begin
    if (o_frame_done === 1'b1) fd_seen++;
    if (o_len_err === 1'b1)    len_err_seen++;
    if (o_sync_lock === 1'b1)  lock_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_bit       = b;
    i_bit_valid = 1'b1;
    tick();
    i_bit_valid = 1'b0;
    i_bit       = ~b;   // garbage while unqualified
  endtask

  // LSB first; with gaps an idle cycle follows every bit (including the last).
  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      if (gaps) tick();
    end
  endtask

  task automatic read_one(input string tag, input logic [7:0] exp);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    check({tag, "_valid"}, 32'(o_rd_valid), 32'd1);
    check({tag, "_data"}, 32'(o_rd_data), 32'(exp));
  endtask

`ifdef SYNC_SEARCH_EN
  task automatic send_sync();
    logic [31:0] pat;
    pat = 32'hA700_0000;
    for (int i = 0; i < 32; i++) send_bit(pat[i]);
  endtask
`endif

  initial begin
    logic [7:0] v;

    i_rst = 1'b1; i_bit = 1'b0; i_bit_valid = 1'b0; i_clear = 1'b0; i_rd_en = 1'b0;
    tick(); tick(); tick();
    i_rst = 1'b0;

    // ---- reset state ----
    check("rst_count",       32'(o_count),        32'd0);
    check("rst_empty",       32'(o_empty),        32'd1);
    check("rst_almost_empty",32'(o_almost_empty), 32'd1);
    check("rst_full",        32'(o_full),         32'd0);
    check("rst_almost_full", 32'(o_almost_full),  32'd0);
    check("rst_overflow",    32'(o_overflow),     32'd0);
    check("rst_underflow",   32'(o_underflow),    32'd0);
    check("rst_rd_valid",    32'(o_rd_valid),     32'd0);
    check("rst_rd_data",     32'(o_rd_data),      32'd0);
    check("rst_sync_lock",   32'(o_sync_lock),    32'd0);

    // ---- read on empty: underflow, no valid ----
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    check("empty_rd_underflow", 32'(o_underflow), 32'd1);
    check("empty_rd_valid",     32'(o_rd_valid),  32'd0);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    check("clear_underflow", 32'(o_underflow), 32'd0);

`ifndef SYNC_SEARCH_EN
    // ---- packing A5 (with idle gaps) and 3C (back-to-back) ----
    send_byte(8'hA5, 1'b1);
    check("pack_a5_count", 32'(o_count), 32'd1);
    send_byte(8'h3C, 1'b0);
    check("pack_latency_count", 32'(o_count), 32'd1);
    tick();
    check("pack_3c_count", 32'(o_count), 32'd2);
    check("no_read_valid", 32'(o_rd_valid), 32'd0);
    read_one("rd_a5", 8'hA5);
    check("rd_a5_count", 32'(o_count), 32'd1);
    tick();
    check("rd_idle_valid", 32'(o_rd_valid), 32'd0);
    check("rd_hold_data",  32'(o_rd_data),  32'hA5);
    read_one("rd_3c", 8'h3C);
    check("drained_empty", 32'(o_empty), 32'd1);

    // ---- read on empty coinciding with a write ----
    v = 8'h81;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    check("rdwr_empty_underflow", 32'(o_underflow), 32'd1);
    check("rdwr_empty_valid",     32'(o_rd_valid),  32'd0);
    check("rdwr_empty_count",     32'(o_count),     32'd1);

    // ---- clear mid-word: partial bits discarded ----
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    check("clr_count",     32'(o_count),     32'd0);
    check("clr_underflow", 32'(o_underflow), 32'd0);
    send_byte(8'h96, 1'b1);
    check("clr_next_count", 32'(o_count), 32'd1);
    read_one("clr_next", 8'h96);

    // ---- fill to exactly DEPTH, checking thresholds on the way ----
    for (int w = 0; w < 128; w++) begin
      send_byte(8'(w) ^ 8'h5A, 1'b0);
      tick();
      if (w == 3)   check("aempty_at_4",  32'(o_almost_empty), 32'd1);
      if (w == 4)   check("aempty_at_5",  32'(o_almost_empty), 32'd0);
      if (w == 122) check("afull_at_123", 32'(o_almost_full),  32'd0);
      if (w == 123) check("afull_at_124", 32'(o_almost_full),  32'd1);
      if (w == 126) check("full_at_127",  32'(o_full),         32'd0);
    end
    check("fill_count",    32'(o_count),    32'd128);
    check("fill_full",     32'(o_full),     32'd1);
    check("fill_overflow", 32'(o_overflow), 32'd0);

    // ---- read + write on full: both accepted ----
    v = 8'hC3;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    check("rdwr_full_valid",    32'(o_rd_valid), 32'd1);
    check("rdwr_full_data",     32'(o_rd_data),  32'h5A);
    check("rdwr_full_count",    32'(o_count),    32'd128);
    check("rdwr_full_overflow", 32'(o_overflow), 32'd0);

    // ---- two more words while full: dropped ----
    send_byte(8'hEE, 1'b0); tick();
    send_byte(8'hEF, 1'b0); tick();
    check("ovf_flag",  32'(o_overflow), 32'd1);
    check("ovf_count", 32'(o_count),    32'd128);
    check("ovf_full",  32'(o_full),     32'd1);

    // ---- drain: words 1..127 then C3, dropped words absent ----
    i_rd_en = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      check("drain_valid", 32'(o_rd_valid), 32'd1);
      check("drain_data",  32'(o_rd_data),  (k == 128) ? 32'hC3 : 32'(8'(k) ^ 8'h5A));
    end
    i_rd_en = 1'b0;
    check("drain_count",     32'(o_count),     32'd0);
    check("drain_empty",     32'(o_empty),     32'd1);
    check("drain_underflow", 32'(o_underflow), 32'd0);

    check("free_frame_done", 32'(fd_seen),      32'd0);
    check("free_len_err",    32'(len_err_seen), 32'd0);
    check("free_sync_lock",  32'(lock_seen),    32'd0);
`else
    // ---- frame: sync + L=3 + 11 22 33 ----
    send_sync();
    check("f1_lock_after_sync", 32'(o_sync_lock), 32'd1);
    check("f1_count_search",    32'(o_count),     32'd0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check("f1_lock_payload", 32'(o_sync_lock), 32'd1);
    send_byte(8'h33, 1'b0);
    check("f1_lock_after", 32'(o_sync_lock), 32'd0);
    tick();
    check("f1_count",      32'(o_count), 32'd4);
    check("f1_frame_done", 32'(fd_seen), 32'd1);
    read_one("f1_w0", 8'h03);
    read_one("f1_w1", 8'h11);
    read_one("f1_w2", 8'h22);
    read_one("f1_w3", 8'h33);

    // ---- length error: L=200 > 127 ----
    send_sync();
    send_byte(8'd200, 1'b0);
    tick();
    check("f2_len_err",   32'(len_err_seen), 32'd1);
    check("f2_count",     32'(o_count),      32'd0);
    check("f2_lock",      32'(o_sync_lock),  32'd0);
    send_sync();
    send_byte(8'h01, 1'b0);
    send_byte(8'h44, 1'b0);
    tick();
    check("f2_next_count", 32'(o_count), 32'd2);
    check("f2_next_done",  32'(fd_seen), 32'd2);
    read_one("f2_w0", 8'h01);
    read_one("f2_w1", 8'h44);

    // ---- clear mid-payload, then a full frame ----
    send_sync();
    send_byte(8'h05, 1'b0);
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    check("f5_count", 32'(o_count),     32'd0);
    check("f5_lock",  32'(o_sync_lock), 32'd0);
    send_sync();
    send_byte(8'h01, 1'b0);
    send_byte(8'h77, 1'b0);
    tick();
    check("f5_next_count", 32'(o_count), 32'd2);
    check("f5_next_done",  32'(fd_seen), 32'd3);
    read_one("f5_w0", 8'h01);
    read_one("f5_w1", 8'h77);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
